line_clear_ctrl: RTL and testbench

Sequencer that owns the board RAM (one word per row, bit x = occupied column x) while a line-clear pass runs. It is started by the game logic when a piece locks. It scans rows bottom-up, compacts non-full rows downward, and zero-fills the vacated top rows. It reports the number of cleared lines. When idle, it passes game-logic board reads and writes straight through to the RAM.

---
 rtl/line_clear_ctrl.sv | 158 +++++++++++++++
 tb/tb_line_clear_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: owns the board RAM during a pass, compacts non-full rows
// downward, zero-fills the vacated top rows, and passes game-logic access through when idle.
module line_clear_ctrl #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20,
   parameter int ROW_AW  = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [4:0]        lines_cleared,
   output logic [15:0]       total_lines,
   input  logic [ROW_AW-1:0] gl_rd_addr,
   input  logic              gl_wr_en,
   input  logic [ROW_AW-1:0] gl_wr_addr,
   input  logic [15:0]       gl_wr_data,
   output logic              gl_wr_drop,
   output logic [ROW_AW-1:0] ram_rd_addr,
   input  logic [15:0]       ram_rd_data,
   output logic              ram_wr_en,
   output logic [ROW_AW-1:0] ram_wr_addr,
   output logic [15:0]       ram_wr_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_EVAL,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [ROW_AW-1:0] LP_LAST_ROW = ROW_AW'(BOARD_H - 1);
   localparam logic [ROW_AW-1:0] LP_ONE      = ROW_AW'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ROW_AW-1:0] r_src;
   logic [ROW_AW-1:0] w_src_nxt;
   logic [ROW_AW-1:0] r_dst;
   logic [ROW_AW-1:0] w_dst_nxt;
   logic [4:0]        r_count;
   logic [4:0]        w_count_nxt;
   logic [4:0]        r_lines;
   logic [15:0]       r_total;
   logic              w_row_full;
   logic              w_enter_done;

   // Only the playable columns decide fullness; upper bits ride along on shifts.
   assign w_row_full   = &ram_rd_data[BOARD_W-1:0];
   assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

   assign busy          = (r_state != S_IDLE);
   assign gl_wr_drop    = busy & gl_wr_en;
   assign lines_cleared = r_lines;
   assign total_lines   = r_total;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_dst_nxt   = r_dst;
      w_count_nxt = r_count;
      done        = 1'b0;
      ram_rd_addr = r_src;
      ram_wr_en   = 1'b0;
      ram_wr_addr = r_dst;
      ram_wr_data = 16'h0000;

      case (r_state)
         S_IDLE: begin
            ram_rd_addr = gl_rd_addr;
            ram_wr_en   = gl_wr_en;
            ram_wr_addr = gl_wr_addr;
            ram_wr_data = gl_wr_data;
            if (start) begin
               w_src_nxt   = LP_LAST_ROW;
               w_dst_nxt   = LP_LAST_ROW;
               w_count_nxt = 5'd0;
               w_state_nxt = S_RD;
            end
         end

         S_RD: begin
            w_state_nxt = S_EVAL;
         end

         S_EVAL: begin
            if (w_row_full) begin
               w_count_nxt = r_count + 5'd1;
            end else begin
               // A nonzero count means dst has fallen behind src, so the row must move.
               if (r_count != 5'd0) begin
                  ram_wr_en   = 1'b1;
                  ram_wr_data = ram_rd_data;
               end
               if (r_dst != '0) begin
                  w_dst_nxt = r_dst - LP_ONE;
               end
            end

            if (r_src == '0) begin
               w_state_nxt = (w_row_full || (r_count != 5'd0)) ? S_FILL : S_DONE;
            end else begin
               w_src_nxt   = r_src - LP_ONE;
               w_state_nxt = S_RD;
            end
         end

         S_FILL: begin
            ram_wr_en   = 1'b1;
            ram_wr_data = 16'h0000;
            // dst ends the scan at count-1, so stopping at row 0 gives exactly count fills.
            if (r_dst == '0) begin
               w_state_nxt = S_DONE;
            end else begin
               w_dst_nxt = r_dst - LP_ONE;
            end
         end

         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_count <= 5'd0;
         r_lines <= 5'd0;
         r_total <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_src   <= w_src_nxt;
         r_dst   <= w_dst_nxt;
         r_count <= w_count_nxt;
         // Results are latched on entry to DONE so they are already valid with done.
         if (w_enter_done) begin
            r_lines <= w_count_nxt;
            r_total <= r_total + 16'(w_count_nxt);
         end
      end
   end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: a RAM model, a stimulus process that queues
// expected pass results, and a monitor that checks them whenever done or gl_wr_drop fires.
module tb_line_clear_ctrl;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int ROW_AW  = 5;

   typedef struct {
      int lines;
      int total;
      int lat;
      int writes;
   } exp_t;

   logic              Clk;
   logic              Reset;
   logic              start;
   logic              busy;
   logic              done;
   logic [4:0]        lines_cleared;
   logic [15:0]       total_lines;
   logic [ROW_AW-1:0] gl_rd_addr;
   logic              gl_wr_en;
   logic [ROW_AW-1:0] gl_wr_addr;
   logic [15:0]       gl_wr_data;
   logic              gl_wr_drop;
   logic [ROW_AW-1:0] ram_rd_addr;
   logic [15:0]       ram_rd_data;
   logic              ram_wr_en;
   logic [ROW_AW-1:0] ram_wr_addr;
   logic [15:0]       ram_wr_data;

   logic [15:0] mem     [0:31];
   logic [15:0] brd     [0:BOARD_H-1];
   logic [15:0] exp_brd [0:BOARD_H-1];

   exp_t q_done [$];
   int   q_drop [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   line_clear_ctrl #(
      .BOARD_W(BOARD_W),
      .BOARD_H(BOARD_H),
      .ROW_AW (ROW_AW)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .lines_cleared(lines_cleared),
      .total_lines  (total_lines),
      .gl_rd_addr   (gl_rd_addr),
      .gl_wr_en     (gl_wr_en),
      .gl_wr_addr   (gl_wr_addr),
      .gl_wr_data   (gl_wr_data),
      .gl_wr_drop   (gl_wr_drop),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .ram_wr_en    (ram_wr_en),
      .ram_wr_addr  (ram_wr_addr),
      .ram_wr_data  (ram_wr_data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Synchronous-read RAM with one cycle of read latency.
   always @(posedge Clk) begin
      ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Monitor: tracks pass cycle index and RAM writes, and pops expectations on output events.
   initial begin
      int   cyc;
      int   wcnt;
      logic prev_busy;
      exp_t e;
      cyc       = 0;
      wcnt      = 0;
      prev_busy = 1'b0;
      forever begin
         @(negedge Clk);
         if (busy === 1'b1) begin
            if (!prev_busy) begin
               cyc  = 0;
               wcnt = 0;
            end else begin
               cyc++;
            end
            if (ram_wr_en === 1'b1) wcnt++;
         end
         if (done === 1'b1) begin
            if (q_done.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q_done.pop_front();
               check("lines_cleared", 32'(lines_cleared), 32'(e.lines));
               check("total_lines", 32'(total_lines), 32'(e.total));
               check("done_cycle", 32'(cyc), 32'(e.lat));
               check("pass_ram_writes", 32'(wcnt), 32'(e.writes));
            end
         end
         if (gl_wr_drop === 1'b1) begin
            if (q_drop.size() == 0) begin
               check("unexpected_drop", 32'd1, 32'd0);
            end else begin
               check("drop_addr", 32'(gl_wr_addr), 32'(q_drop.pop_front()));
            end
         end
         prev_busy = (busy === 1'b1);
      end
   end

   task automatic clear_arrays();
      for (int i = 0; i < BOARD_H; i++) begin
         brd[i]     = 16'h0000;
         exp_brd[i] = 16'h0000;
      end
   endtask

   task automatic load_board();
      for (int i = 0; i < BOARD_H; i++) begin
         gl_wr_en   = 1'b1;
         gl_wr_addr = ROW_AW'(i);
         gl_wr_data = brd[i];
         tick();
      end
      gl_wr_en = 1'b0;
   endtask

   task automatic check_board(input string tag);
      for (int i = 0; i < BOARD_H; i++) begin
         check($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(exp_brd[i]));
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 150) begin
         tick();
         n++;
      end
      check("done_within_budget", 32'(done), 32'd1);
   endtask

   task automatic run_pass(input int lines, input int total, input int lat, input int writes);
      exp_t e;
      e.lines  = lines;
      e.total  = total;
      e.lat    = lat;
      e.writes = writes;
      q_done.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      tick();
      check("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      Reset      = 1'b0;
      start      = 1'b0;
      gl_rd_addr = '0;
      gl_wr_en   = 1'b0;
      gl_wr_addr = '0;
      gl_wr_data = 16'h0000;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_drop", 32'(gl_wr_drop), 32'd0);
      check("rst_lines", 32'(lines_cleared), 32'd0);
      check("rst_total", 32'(total_lines), 32'd0);
      Reset = 1'b1;
      tick();

      // Test 1: empty board.
      clear_arrays();
      load_board();
      run_pass(0, 0, 40, 0);
      check_board("t1");

      // Test 2: one full bottom row.
      clear_arrays();
      brd[19] = 16'h03FF;
      brd[18] = 16'h0001;
      exp_brd[19] = 16'h0001;
      load_board();
      run_pass(1, 1, 41, 20);
      check_board("t2");

      // Test 3: four full rows at the bottom.
      clear_arrays();
      for (int i = 16; i < 20; i++) brd[i] = 16'h03FF;
      brd[15] = 16'h0200;
      exp_brd[19] = 16'h0200;
      load_board();
      run_pass(4, 5, 44, 20);
      check_board("t3");

      // Test 4: interleaved full rows, upper bits preserved.
      clear_arrays();
      brd[19] = 16'h03FF;
      brd[18] = 16'h0003;
      brd[17] = 16'h03FF;
      brd[16] = 16'h0100;
      brd[15] = 16'hFC01;
      exp_brd[19] = 16'h0003;
      exp_brd[18] = 16'h0100;
      exp_brd[17] = 16'hFC01;
      load_board();
      run_pass(2, 7, 42, 20);
      check_board("t4");

      // Test 5: start and write while busy, start during done, then idle passthrough.
      clear_arrays();
      load_board();
      e.lines  = 0;
      e.total  = 7;
      e.lat    = 40;
      e.writes = 0;
      q_done.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start      = 1'b1;
      gl_wr_en   = 1'b1;
      gl_wr_addr = 5'd3;
      gl_wr_data = 16'h0055;
      q_drop.push_back(3);
      tick();
      start    = 1'b0;
      gl_wr_en = 1'b0;
      wait_done();
      start = 1'b1;
      tick();
      check("start_in_done_ignored", 32'(busy), 32'd0);
      q_done.push_back(e);
      tick();
      start = 1'b0;
      wait_done();
      tick();
      check_board("t5");

      gl_wr_en   = 1'b1;
      gl_wr_addr = 5'd3;
      gl_wr_data = 16'h0055;
      #1;
      check("idle_wr_en_passthru", 32'(ram_wr_en), 32'd1);
      check("idle_wr_addr_passthru", 32'(ram_wr_addr), 32'd3);
      check("idle_wr_data_passthru", 32'(ram_wr_data), 32'h0055);
      check("idle_no_drop", 32'(gl_wr_drop), 32'd0);
      tick();
      gl_wr_en = 1'b0;
      check("idle_write_row3", 32'(mem[3]), 32'h0055);
      gl_rd_addr = 5'd3;
      tick();
      check("idle_read_row3", 32'(ram_rd_data), 32'h0055);
      gl_rd_addr = '0;

      // Test 6: reset in cycle 10 of a pass, then a normal pass.
      clear_arrays();
      brd[19] = 16'h03FF;
      brd[18] = 16'h0001;
      load_board();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      Reset = 1'b0;
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_wr_en", 32'(ram_wr_en), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_lines", 32'(lines_cleared), 32'd0);
      check("midrst_total", 32'(total_lines), 32'd0);
      Reset = 1'b1;
      tick();
      load_board();
      exp_brd[19] = 16'h0001;
      run_pass(1, 1, 41, 20);
      check_board("t6");

      repeat (2) tick();
      check("done_queue_drained", 32'(q_done.size()), 32'd0);
      check("drop_queue_drained", 32'(q_drop.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
